fp_add_result_pack: RTL and testbench

Downstream stage of the single-precision adder. Captures each unpacked result (sign, exponent, mantissa) on the adder's result-valid strobe and repacks it into a 32-bit IEEE-754 word. Results are buffered in a small FIFO and presented on a valid/ready stream to the consumer. The adder cannot be stalled, so any result that arrives while the buffer is full is dropped, flagged and counted.

---
 rtl/fp_add_result_pack_if.sv | 32 +++
 rtl/fp_add_result_pack.sv | 111 +++++++++++
 tb/tb_fp_add_result_pack.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fp_add_result_pack_if.sv
// Stream bundle between the adder result port, the repacking FIFO and the consumer.
// Optional macro FP_RESULT_PACK_CLASS_EN adds the out_class field to the bundle.
interface fp_add_result_pack_if;
  logic        dst_valid;
  logic [22:0] r_man;
  logic [7:0]  r_exp;
  logic        r_sign;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef FP_RESULT_PACK_CLASS_EN
  logic [3:0]  out_class;
`endif

  // master: adder/consumer side (drives results and ready, observes the stream)
  modport master (
    output dst_valid, r_man, r_exp, r_sign, out_ready,
`ifdef FP_RESULT_PACK_CLASS_EN
    input  out_class,
`endif
    input  out_valid, out_data
  );

  // slave: the repacking FIFO
  modport slave (
    input  dst_valid, r_man, r_exp, r_sign, out_ready,
`ifdef FP_RESULT_PACK_CLASS_EN
    output out_class,
`endif
    output out_valid, out_data
  );
endinterface

// File: rtl/fp_add_result_pack.sv
// Repacks unpacked adder results into IEEE-754 single words and buffers them
// in a DEPTH-entry FIFO with a valid/ready output. The adder cannot stall, so
// results arriving while full are dropped, flagged (sticky) and counted.
// Optional macro FP_RESULT_PACK_CLASS_EN stores a 4-bit class per entry
// {nan, inf, zero, denorm} and drives out_class.
module fp_add_result_pack #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  fp_add_result_pack_if.slave      bus,
  input  logic                     clr_overflow,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [7:0]               drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
`ifdef FP_RESULT_PACK_CLASS_EN
  localparam int EW = 36;
`else
  localparam int EW = 32;
`endif

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_overflow;
  logic [7:0]    r_drop_count;

  logic          w_full;
  logic          w_valid;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [EW-1:0] w_entry;
  logic [EW-1:0] w_head;

  assign w_full  = (r_level == LVL_FULL);
  assign w_valid = (r_level != '0);
  assign w_pop   = w_valid && bus.out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_push  = bus.dst_valid && (!w_full || w_pop);
  assign w_drop  = bus.dst_valid && w_full && !w_pop;

`ifdef FP_RESULT_PACK_CLASS_EN
  logic [3:0] w_class;
  logic       w_exp_max;
  logic       w_exp_zero;
  logic       w_man_zero;

  assign w_exp_max  = (bus.r_exp == 8'hFF);
  assign w_exp_zero = (bus.r_exp == 8'h00);
  assign w_man_zero = (bus.r_man == 23'd0);
  assign w_class    = {w_exp_max && !w_man_zero, w_exp_max && w_man_zero,
                       w_exp_zero && w_man_zero, w_exp_zero && !w_man_zero};
  assign w_entry    = {w_class, bus.r_sign, bus.r_exp, bus.r_man};
`else
  assign w_entry    = {bus.r_sign, bus.r_exp, bus.r_man};
`endif

  // Head is forced to zero when empty so the output is clean after reset.
  assign w_head        = w_valid ? r_mem[r_rd_ptr] : '0;
  assign bus.out_valid = w_valid;
  assign bus.out_data  = w_head[31:0];
`ifdef FP_RESULT_PACK_CLASS_EN
  assign bus.out_class = w_head[35:32];
`endif

  assign level      = r_level;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

  // Storage write; contents need no reset because level gates visibility.
  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky drop flag (a drop beats a clear) and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (w_drop)            r_overflow <= 1'b1;
      else if (clr_overflow) r_overflow <= 1'b0;
      if (w_drop && (r_drop_count != 8'hFF)) r_drop_count <= r_drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_add_result_pack.sv
// Directed bench for fp_add_result_pack. Inputs change 1 time unit after a
// rising edge; outputs are checked at that same point, after the edge settled.
module tb_fp_add_result_pack;
  logic       clk = 1'b0;
  logic       rst;
  logic       clr_overflow;
  logic [2:0] level;
  logic       overflow;
  logic [7:0] drop_count;
  int         n_err = 0;
  int         n_chk = 0;

  fp_add_result_pack_if intf ();

  fp_add_result_pack #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (intf),
    .clr_overflow (clr_overflow),
    .level        (level),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] e, input logic [22:0] m);
    intf.dst_valid = v;
    intf.r_sign    = s;
    intf.r_exp     = e;
    intf.r_man     = m;
  endtask

  initial begin
    rst = 1'b1;
    clr_overflow = 1'b0;
    intf.out_ready = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 23'd0);
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_valid", 32'(intf.out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drops", 32'(drop_count), 32'd0);
    chk("rst_data", intf.out_data, 32'd0);

    // single result, consumer ready
    intf.out_ready = 1'b1;
    drive(1'b1, 1'b1, 8'h80, 23'h400000);
    cyc();
    drive(1'b0, 1'b0, 8'h00, 23'd0);
    chk("single_valid", 32'(intf.out_valid), 32'd1);
    chk("single_data", intf.out_data, 32'hC0400000);
    chk("single_level", 32'(level), 32'd1);
    cyc();
    chk("single_popped_level", 32'(level), 32'd0);
    chk("single_popped_valid", 32'(intf.out_valid), 32'd0);

    // fill with 1..4 while stalled, then a fifth is dropped
    intf.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b0, 8'h01, 23'(i));
      cyc();
    end
    chk("fill_level", 32'(level), 32'd4);
    chk("fill_ovf", 32'(overflow), 32'd0);
    drive(1'b1, 1'b0, 8'h01, 23'd5);
    cyc();
    drive(1'b0, 1'b0, 8'h00, 23'd0);
    chk("drop_level", 32'(level), 32'd4);
    chk("drop_ovf", 32'(overflow), 32'd1);
    chk("drop_count1", 32'(drop_count), 32'd1);
    chk("drop_head", intf.out_data, 32'h00800001);
    cyc();
    chk("head_stable", intf.out_data, 32'h00800001);

    // clear alone
    clr_overflow = 1'b1;
    cyc();
    clr_overflow = 1'b0;
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_drops_kept", 32'(drop_count), 32'd1);

    // full: simultaneous pop and push
    intf.out_ready = 1'b1;
    drive(1'b1, 1'b0, 8'h01, 23'd6);
    cyc();
    drive(1'b0, 1'b0, 8'h00, 23'd0);
    chk("pp_level", 32'(level), 32'd4);
    chk("pp_ovf", 32'(overflow), 32'd0);
    chk("pp_drops", 32'(drop_count), 32'd1);
    chk("drain_2", intf.out_data, 32'h00800002);
    cyc();
    chk("drain_3", intf.out_data, 32'h00800003);
    cyc();
    chk("drain_4", intf.out_data, 32'h00800004);
    cyc();
    chk("drain_6", intf.out_data, 32'h00800006);
    cyc();
    chk("drain_level", 32'(level), 32'd0);
    chk("drain_valid", 32'(intf.out_valid), 32'd0);

    // refill, then a drop coincident with clr_overflow
    intf.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 8'h02, 23'(16 + i));
      cyc();
    end
    clr_overflow = 1'b1;
    drive(1'b1, 1'b0, 8'h02, 23'd30);
    cyc();
    clr_overflow = 1'b0;
    chk("clr_drop_ovf", 32'(overflow), 32'd1);
    chk("clr_drop_count", 32'(drop_count), 32'd2);
    for (int i = 0; i < 298; i++) cyc();
    drive(1'b0, 1'b0, 8'h00, 23'd0);
    chk("sat_count", 32'(drop_count), 32'd255);
    chk("sat_level", 32'(level), 32'd4);
    chk("sat_head", intf.out_data, 32'h01000010);

    // reset with three buffered entries, dst_valid during reset ignored
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 8'h03, 23'(40 + i));
      cyc();
    end
    drive(1'b0, 1'b0, 8'h00, 23'd0);
    chk("pre_rst_level", 32'(level), 32'd3);
    rst = 1'b1;
    drive(1'b1, 1'b1, 8'h04, 23'd50);
    cyc();
    rst = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 23'd0);
    chk("mid_rst_valid", 32'(intf.out_valid), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_drops", 32'(drop_count), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    intf.out_ready = 1'b1;
    drive(1'b1, 1'b0, 8'h05, 23'd9);
    cyc();
    drive(1'b0, 1'b0, 8'h00, 23'd0);
    chk("post_rst_data", intf.out_data, 32'h02800009);
    chk("post_rst_level", 32'(level), 32'd1);
    cyc();
    chk("post_rst_empty", 32'(intf.out_valid), 32'd0);

`ifdef FP_RESULT_PACK_CLASS_EN
    begin
      logic [7:0]  c_exp [5];
      logic [22:0] c_man [5];
      logic [3:0]  c_cls [5];
      c_exp = '{8'd255, 8'd255, 8'd0, 8'd0, 8'd127};
      c_man = '{23'd1, 23'd0, 23'd0, 23'd5, 23'd0};
      c_cls = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000};
      for (int i = 0; i < 5; i++) begin
        drive(1'b1, 1'b0, c_exp[i], c_man[i]);
        cyc();
        chk("class", 32'(intf.out_class), 32'(c_cls[i]));
        chk("class_data", intf.out_data, {1'b0, c_exp[i], c_man[i]});
      end
      drive(1'b0, 1'b0, 8'h00, 23'd0);
      cyc();
      chk("class_empty", 32'(intf.out_class), 32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
